// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and loads IF/ID.
// Redirects that arrive while memory is busy are parked until the access completes.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PC_MUX_CONTROL,
  input  logic [31:0] BRANCH_OR_JUMP_ADDR,
  input  logic        REG_FLUSH,
  input  logic        HAZARD_STALL,
  input  logic        IMEM_BUSYWAIT,
  input  logic [31:0] IMEM_INSTR,
  output logic [31:0] IMEM_ADDR,
  output logic        IMEM_READ,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_PC4,
  output logic [31:0] IF_ID_INSTR,
  output logic        IF_ID_VALID
);

  typedef enum logic {
    ST_RUN,
    ST_REDIRECT_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_addr_q, pending_addr_d;
  logic        imem_read_q, imem_read_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_pc4_q, if_id_pc4_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;

  logic [31:0] target_aligned;
  logic [31:0] pc_plus4;

  assign target_aligned = BRANCH_OR_JUMP_ADDR & ~32'h0000_0003;
  assign pc_plus4       = pc_q + 32'd4;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    pending_addr_d = pending_addr_q;
    imem_read_d    = 1'b1;
    if_id_pc_d     = if_id_pc_q;
    if_id_pc4_d    = if_id_pc4_q;
    if_id_instr_d  = if_id_instr_q;
    if_id_valid_d  = if_id_valid_q;

    case (state_q)
      ST_RUN: begin
        if (PC_MUX_CONTROL) begin
          if_id_instr_d = NOP_INSTR;
          if_id_valid_d = 1'b0;
          if (IMEM_BUSYWAIT) begin
            // PC must stay put so the in-flight access sees a stable address.
            pending_addr_d = target_aligned;
            state_d        = ST_REDIRECT_HOLD;
          end else begin
            pc_d = target_aligned;
          end
        end else begin
          if (HAZARD_STALL) begin
            // PC and IF/ID hold
          end else if (IMEM_BUSYWAIT) begin
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
          end else begin
            if_id_pc_d    = pc_q;
            if_id_pc4_d   = pc_plus4;
            if_id_instr_d = IMEM_INSTR;
            if_id_valid_d = 1'b1;
            pc_d          = pc_plus4;
          end
          // A flush overrides whatever IF/ID would have taken; PC still advances as above.
          if (REG_FLUSH) begin
            if_id_instr_d = NOP_INSTR;
            if_id_valid_d = 1'b0;
          end
        end
      end

      ST_REDIRECT_HOLD: begin
        if_id_instr_d = NOP_INSTR;
        if_id_valid_d = 1'b0;
        if (PC_MUX_CONTROL) begin
          pending_addr_d = target_aligned;
        end
        if (!IMEM_BUSYWAIT) begin
          pc_d    = PC_MUX_CONTROL ? target_aligned : pending_addr_q;
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q        <= ST_RUN;
      pc_q           <= RESET_PC;
      pending_addr_q <= '0;
      imem_read_q    <= 1'b0;
      if_id_pc_q     <= '0;
      if_id_pc4_q    <= '0;
      if_id_instr_q  <= NOP_INSTR;
      if_id_valid_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      pending_addr_q <= pending_addr_d;
      imem_read_q    <= imem_read_d;
      if_id_pc_q     <= if_id_pc_d;
      if_id_pc4_q    <= if_id_pc4_d;
      if_id_instr_q  <= if_id_instr_d;
      if_id_valid_q  <= if_id_valid_d;
    end
  end

  assign IMEM_ADDR   = pc_q;
  assign IMEM_READ   = imem_read_q;
  assign IF_ID_PC    = if_id_pc_q;
  assign IF_ID_PC4   = if_id_pc4_q;
  assign IF_ID_INSTR = if_id_instr_q;
  assign IF_ID_VALID = if_id_valid_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios then random traffic, every cycle
// compared against a rule-level model of the fetch stage.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        PC_MUX_CONTROL;
  logic [31:0] BRANCH_OR_JUMP_ADDR;
  logic        REG_FLUSH;
  logic        HAZARD_STALL;
  logic        IMEM_BUSYWAIT;
  logic [31:0] IMEM_INSTR;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_READ;
  logic [31:0] IF_ID_PC;
  logic [31:0] IF_ID_PC4;
  logic [31:0] IF_ID_INSTR;
  logic        IF_ID_VALID;

  pc_fetch_unit #(
    .RESET_PC (RST_PC),
    .NOP_INSTR(NOP)
  ) dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .PC_MUX_CONTROL     (PC_MUX_CONTROL),
    .BRANCH_OR_JUMP_ADDR(BRANCH_OR_JUMP_ADDR),
    .REG_FLUSH          (REG_FLUSH),
    .HAZARD_STALL       (HAZARD_STALL),
    .IMEM_BUSYWAIT      (IMEM_BUSYWAIT),
    .IMEM_INSTR         (IMEM_INSTR),
    .IMEM_ADDR          (IMEM_ADDR),
    .IMEM_READ          (IMEM_READ),
    .IF_ID_PC           (IF_ID_PC),
    .IF_ID_PC4          (IF_ID_PC4),
    .IF_ID_INSTR        (IF_ID_INSTR),
    .IF_ID_VALID        (IF_ID_VALID)
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model state
  logic [31:0] m_pc, m_pend, m_ifpc, m_ifpc4, m_ifinstr;
  logic        m_pending, m_read, m_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic bubble();
    m_ifinstr = NOP;
    m_valid   = 1'b0;
  endtask

  // Applies the fetch rules to the inputs currently being driven.
  task automatic model_step();
    logic [31:0] tgt;
    tgt = {BRANCH_OR_JUMP_ADDR[31:2], 2'b00};
    if (RESET) begin
      m_pc = RST_PC; m_pend = '0; m_pending = 1'b0; m_read = 1'b0;
      m_ifpc = '0; m_ifpc4 = '0; m_ifinstr = NOP; m_valid = 1'b0;
      return;
    end
    m_read = 1'b1;
    if (m_pending) begin
      bubble();
      if (PC_MUX_CONTROL) m_pend = tgt;
      if (!IMEM_BUSYWAIT) begin
        m_pc      = m_pend;
        m_pending = 1'b0;
      end
    end else if (PC_MUX_CONTROL) begin
      bubble();
      if (IMEM_BUSYWAIT) begin
        m_pend    = tgt;
        m_pending = 1'b1;
      end else begin
        m_pc = tgt;
      end
    end else begin
      if (!HAZARD_STALL && !IMEM_BUSYWAIT) begin
        m_ifpc    = m_pc;
        m_ifpc4   = m_pc + 32'd4;
        m_ifinstr = IMEM_INSTR;
        m_valid   = 1'b1;
        m_pc      = m_pc + 32'd4;
      end else if (!HAZARD_STALL) begin
        bubble();
      end
      if (REG_FLUSH) bubble();
    end
  endtask

  task automatic step();
    model_step();
    @(posedge CLK);
    #1;
    chk("imem_addr", IMEM_ADDR, m_pc);
    chk("imem_read", {31'd0, IMEM_READ}, {31'd0, m_read});
    chk("if_id_valid", {31'd0, IF_ID_VALID}, {31'd0, m_valid});
    chk("if_id_instr", IF_ID_INSTR, m_ifinstr);
    if (m_valid) begin
      chk("if_id_pc", IF_ID_PC, m_ifpc);
      chk("if_id_pc4", IF_ID_PC4, m_ifpc4);
    end
  endtask

  task automatic drive(input logic rst, input logic pmc, input logic [31:0] tgt,
                       input logic fl, input logic st, input logic busy);
    RESET = rst; PC_MUX_CONTROL = pmc; BRANCH_OR_JUMP_ADDR = tgt;
    REG_FLUSH = fl; HAZARD_STALL = st; IMEM_BUSYWAIT = busy;
    IMEM_INSTR = $urandom;
  endtask

  initial begin
    logic [31:0] held_instr;
    drive(1, 0, 0, 0, 0, 0);
    m_pc = 'x; m_pend = '0; m_pending = 0; m_read = 0;
    m_ifpc = '0; m_ifpc4 = '0; m_ifinstr = NOP; m_valid = 0;
    #2;
    step();
    step();
    chk("reset_pc", IF_ID_PC, 32'h0);
    chk("reset_pc4", IF_ID_PC4, 32'h0);
    chk("reset_addr", IMEM_ADDR, RST_PC);

    // Sequential run: 0,4,8,12 then PC reaches 0x10
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0);
      step();
    end
    chk("seq_addr", IMEM_ADDR, 32'h10);
    chk("seq_ifpc", IF_ID_PC, 32'hC);

    // Idle redirect to 0x100
    drive(0, 1, 32'h100, 0, 0, 0);
    step();
    chk("redir_nop", IF_ID_INSTR, NOP);
    chk("redir_addr", IMEM_ADDR, 32'h100);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("redir_target_ifpc", IF_ID_PC, 32'h100);

    // Busy redirect from 0x20 to 0x204
    drive(0, 1, 32'h20, 0, 0, 0);
    step();
    drive(0, 1, 32'h204, 0, 0, 1);
    step();
    chk("busy_hold1", IMEM_ADDR, 32'h20);
    drive(0, 0, 0, 0, 1, 1);
    step();
    drive(0, 0, 0, 0, 0, 1);
    step();
    chk("busy_hold3", IMEM_ADDR, 32'h20);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("busy_target", IMEM_ADDR, 32'h204);
    step();

    // Stall holds PC and IF/ID; stall with redirect takes the redirect
    held_instr = IF_ID_INSTR;
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 1, 0);
      step();
    end
    chk("stall_instr_held", IF_ID_INSTR, held_instr);
    drive(0, 1, 32'hFFFF_FFF8, 0, 1, 0);
    step();
    chk("stall_redir_addr", IMEM_ADDR, 32'hFFFF_FFF8);

    // Wrap past 0xFFFF_FFFC
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("wrap_addr", IMEM_ADDR, 32'h0);
    chk("wrap_pc4", IF_ID_PC4, 32'h0);

    // Unaligned target, then a lone flush
    drive(0, 1, 32'h103, 0, 0, 0);
    step();
    chk("align_addr", IMEM_ADDR, 32'h100);
    drive(0, 0, 0, 1, 0, 0);
    step();
    chk("flush_addr", IMEM_ADDR, 32'h104);

    // Reset while a redirect is pending
    drive(0, 1, 32'h800, 0, 0, 1);
    step();
    drive(1, 0, 0, 0, 0, 1);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("rst_hold_addr", IMEM_ADDR, 32'h4);
    step();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom % 60) == 0, ($urandom % 5) == 0, $urandom,
            ($urandom % 6) == 0, ($urandom % 4) == 0, ($urandom % 3) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Instruction-fetch stage. Owns the program counter, drives the instruction memory, and loads the IF/ID pipeline register.
- Consumes the redirect outputs of the jump controller in EX: PC_MUX_CONTROL, BRANCH_OR_JUMP_ADDR and REG_FLUSH.
- Handles the hazard-unit stall and memory busywait. A redirect that arrives while memory is busy is held pending and applied when the memory completes.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0013, instruction word (addi x0,x0,0) inserted into IF/ID on a bubble or flush.

Ports:
CLK  input  1  single clock; all state updates on the rising edge.
RESET  input  1  synchronous, active-high reset.
PC_MUX_CONTROL  input  1  redirect request from the jump controller.
BRANCH_OR_JUMP_ADDR  input  32  redirect target.
REG_FLUSH  input  1  flush request for IF/ID.
HAZARD_STALL  input  1  load-use stall from the hazard unit.
IMEM_BUSYWAIT  input  1  instruction memory has not completed the current access.
IMEM_INSTR  input  32  instruction word; valid when IMEM_BUSYWAIT=0.
IMEM_ADDR  output  32  fetch address (combinational from the PC register).
IMEM_READ  output  1  read enable (registered).
IF_ID_PC  output  32  PC of the instruction held in IF/ID.
IF_ID_PC4  output  32  IF_ID_PC+4.
IF_ID_INSTR  output  32  instruction held in IF/ID.
IF_ID_VALID  output  1  1 when IF/ID holds a real instruction.

Behaviour:
- Reset: reset is synchronous and active-high. On a rising CLK edge with RESET=1, the block loads:
  - PC=RESET_PC, IMEM_READ=0, state=RUN, PENDING_ADDR=0
  - IF_ID_PC=0, IF_ID_PC4=0, IF_ID_INSTR=NOP_INSTR, IF_ID_VALID=0
- After reset: IMEM_READ=1 from the first non-reset edge onward. Reset mid-operation aborts everything, including a pending redirect.
- IMEM_ADDR=PC at all times. Targets are word-aligned: PC loads {addr[31:2],2'b00}. PC+4 wraps modulo 2^32.
- States: RUN and REDIRECT_HOLD.
- RUN, evaluated in priority order each edge:
  1. PC_MUX_CONTROL=1 and IMEM_BUSYWAIT=0: PC<=target; IF/ID<=bubble (NOP_INSTR, VALID=0). Overrides HAZARD_STALL.
  2. PC_MUX_CONTROL=1 and IMEM_BUSYWAIT=1: PENDING_ADDR<=target; IF/ID<=bubble; PC holds, so IMEM_ADDR stays stable for the in-flight access; go to REDIRECT_HOLD.
  3. REG_FLUSH=1 without PC_MUX_CONTROL: IF/ID<=bubble; PC follows rules 4-6.
  4. HAZARD_STALL=1: PC and IF/ID hold.
  5. IMEM_BUSYWAIT=1: PC holds; IF/ID<=bubble.
  6. Otherwise: IF/ID<={PC, PC+4, IMEM_INSTR, 1}; PC<=PC+4.
- REDIRECT_HOLD:
  - IF/ID holds a bubble. HAZARD_STALL is ignored.
  - A new PC_MUX_CONTROL=1 overwrites PENDING_ADDR (latest target wins).
  - When IMEM_BUSYWAIT=0: the returned IMEM_INSTR is discarded; PC<=PENDING_ADDR, or the new target if PC_MUX_CONTROL=1 in that same cycle; go to RUN.
- Latency:
  - A fetch issued at PC with no busywait appears in IF/ID one edge later.
  - A redirect with memory idle costs 1 bubble. The target's instruction reaches IF/ID 2 edges after the redirect cycle.
- No instruction is ever both written to IF/ID and discarded. IF_ID_VALID=0 always pairs with IF_ID_INSTR=NOP_INSTR.

Test Plan:
- Reset then sequential run: RESET=1 for 2 cycles, IMEM_BUSYWAIT=0 -> IMEM_ADDR 0,4,8,12 on successive cycles; IF_ID_PC lags by one edge with IF_ID_VALID=1; IF_ID_PC4=IF_ID_PC+4.
- Idle-memory redirect: at PC=0x10, PC_MUX_CONTROL=1, target=0x100 -> next edge IF_ID_VALID=0 with NOP 0x00000013, PC=0x100; following edge IF_ID_PC=0x100.
- Busy redirect: at PC=0x20, IMEM_BUSYWAIT=1 for 3 cycles, redirect to 0x204 on the first -> IMEM_ADDR held at 0x20 throughout; after busywait drops, PC=0x204; the instruction returned for 0x20 never appears with VALID=1.
- Stall vs redirect: HAZARD_STALL=1 for 2 cycles -> PC and IF/ID unchanged. HAZARD_STALL=1 together with PC_MUX_CONTROL=1 -> redirect taken, IF/ID bubbled.
- Wrap and alignment: PC=0xFFFF_FFFC -> next PC=0x0000_0000. Redirect target 0x0000_0103 -> PC=0x0000_0100.
- Reset in REDIRECT_HOLD: RESET asserted while pending -> PC=RESET_PC, state RUN, the pending target is never fetched.
